// File: rtl/lab2_proc_mem_responder_if.sv
// Val/rdy request and response streams between a processor memory port and its responder.
// master = processor side, slave = memory responder side.
interface lab2_proc_mem_responder_if;
    logic        reqstream_val;
    logic        reqstream_rdy;
    logic [76:0] reqstream_msg;
    logic        respstream_val;
    logic        respstream_rdy;
    logic [46:0] respstream_msg;

    modport master (
        output reqstream_val, reqstream_msg, respstream_rdy,
        input  reqstream_rdy, respstream_val, respstream_msg
    );

    modport slave (
        input  reqstream_val, reqstream_msg, respstream_rdy,
        output reqstream_rdy, respstream_val, respstream_msg
    );
endinterface

// File: rtl/lab2_proc_mem_responder.sv
// Fixed-latency test memory behind a processor val/rdy port; responses buffered in an in-order FIFO.
// Optional: define LAB2_PROC_MEM_OOB_CHECK_EN to flag and suppress accesses beyond the array.
module lab2_proc_mem_responder #(
    parameter int p_mem_words = 256,
    parameter int p_latency   = 2,
    parameter int p_depth     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    lab2_proc_mem_responder_if.slave      mem
);

    localparam int IW   = $clog2(p_mem_words);
    localparam int NSTG = (p_latency > 1) ? p_latency - 1 : 1;
    localparam int PW   = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int OW   = $clog2(p_depth + 1);

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    mem_req_4B_t  req;
    mem_resp_4B_t in_resp;
    mem_resp_4B_t push_msg;

    logic [31:0]   mem_array [p_mem_words];
    logic [IW-1:0] word_idx;
    logic [1:0]    byte_off;
    logic [2:0]    nbytes;
    logic [3:0]    byte_en;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [31:0]   rd_data;
    logic [31:0]   wr_shift;
    logic          is_write;
    logic          oob;
    logic          accept;
    logic          deliver;
    logic          push;

    logic          stg_val_reg [NSTG];
    mem_resp_4B_t  stg_msg_reg [NSTG];

    mem_resp_4B_t  fifo_mem [p_depth];
    logic [PW-1:0] wr_idx_reg, wr_idx_next;
    logic [PW-1:0] rd_idx_reg, rd_idx_next;
    logic [OW-1:0] fifo_cnt_reg, fifo_cnt_next;
    logic [OW-1:0] outstanding_reg, outstanding_next;
    logic          rdy_reg, rdy_next;

    assign req      = mem.reqstream_msg;
    assign word_idx = req.addr[IW+1:2];
    assign byte_off = req.addr[1:0];
    assign is_write = (req.typ == 3'd1) || (req.typ == 3'd2);

`ifdef LAB2_PROC_MEM_OOB_CHECK_EN
    assign oob = |req.addr[31:IW+2];
`else
    logic unused_hi_addr;
    assign unused_hi_addr = ^req.addr[31:IW+2];
    assign oob = 1'b0;
`endif

    // Byte count after truncating at the end of the addressed word.
    always_comb begin
        nbytes = (req.len == 2'd0) ? 3'd4 : {1'b0, req.len};
        if (({1'b0, byte_off} + nbytes) > 3'd4) begin
            nbytes = 3'd4 - {1'b0, byte_off};
        end
    end

    assign rd_word  = mem_array[word_idx];
    assign rd_shift = rd_word >> {byte_off, 3'b000};
    assign wr_shift = req.data << {byte_off, 3'b000};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_en[gi] = (3'(gi) >= {1'b0, byte_off}) &&
                                 (3'(gi) < ({1'b0, byte_off} + nbytes));
            assign rd_data[8*gi +: 8] = (3'(gi) < nbytes) ? rd_shift[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign accept  = mem.reqstream_val && rdy_reg;
    assign deliver = mem.respstream_val && mem.respstream_rdy;

    always_comb begin
        in_resp        = '0;
        in_resp.typ    = req.typ;
        in_resp.opaque = req.opaque;
        in_resp.test   = oob ? 2'b01 : 2'b00;
        in_resp.len    = req.len;
        in_resp.data   = (is_write || oob) ? 32'h0 : rd_data;
    end

    // Array is deliberately left out of reset so stored program/data survive it.
    always_ff @(posedge clk) begin
        if (accept && is_write && !oob) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_array[word_idx][8*b +: 8] <= wr_shift[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NSTG; k++) begin
                stg_val_reg[k] <= 1'b0;
            end
        end else begin
            stg_val_reg[0] <= accept;
            for (int k = 1; k < NSTG; k++) begin
                stg_val_reg[k] <= stg_val_reg[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        stg_msg_reg[0] <= in_resp;
        for (int k = 1; k < NSTG; k++) begin
            stg_msg_reg[k] <= stg_msg_reg[k-1];
        end
    end

    // The FIFO register itself is the final latency stage.
    generate
        if (p_latency == 1) begin : g_lat1
            assign push     = accept;
            assign push_msg = in_resp;
        end else begin : g_latn
            assign push     = stg_val_reg[NSTG-1];
            assign push_msg = stg_msg_reg[NSTG-1];
        end
    endgenerate

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(p_depth - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_idx_reg] <= push_msg;
        end
    end

    always_comb begin
        wr_idx_next      = push ? ptr_inc(wr_idx_reg) : wr_idx_reg;
        rd_idx_next      = deliver ? ptr_inc(rd_idx_reg) : rd_idx_reg;
        fifo_cnt_next    = fifo_cnt_reg + OW'(push) - OW'(deliver);
        outstanding_next = outstanding_reg + OW'(accept) - OW'(deliver);
        rdy_next         = (outstanding_next < OW'(p_depth));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_idx_reg      <= '0;
            rd_idx_reg      <= '0;
            fifo_cnt_reg    <= '0;
            outstanding_reg <= '0;
            rdy_reg         <= 1'b0;
        end else begin
            wr_idx_reg      <= wr_idx_next;
            rd_idx_reg      <= rd_idx_next;
            fifo_cnt_reg    <= fifo_cnt_next;
            outstanding_reg <= outstanding_next;
            rdy_reg         <= rdy_next;
        end
    end

    assign mem.reqstream_rdy  = rdy_reg;
    assign mem.respstream_val = (fifo_cnt_reg != '0);
    assign mem.respstream_msg = fifo_mem[rd_idx_reg];

endmodule

// File: tb/tb_lab2_proc_mem_responder.sv
// Self-checking bench: vector table plus directed streaming, backpressure, reset and aliasing sequences.
module tb_lab2_proc_mem_responder;

    localparam int LAT = 2;

`ifdef LAB2_PROC_MEM_OOB_CHECK_EN
    localparam logic [31:0] SUB_BASE   = 32'h0000_0100;
    localparam logic [1:0]  ALIAS_TEST = 2'b01;
    localparam logic [31:0] ALIAS_READ = 32'h1111_1111;
`else
    localparam logic [31:0] SUB_BASE   = 32'h0000_1000;
    localparam logic [1:0]  ALIAS_TEST = 2'b00;
    localparam logic [31:0] ALIAS_READ = 32'hA5A5_A5A5;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lab2_proc_mem_responder_if mif();

    lab2_proc_mem_responder #(
        .p_mem_words(256),
        .p_latency  (LAT),
        .p_depth    (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .mem  (mif)
    );

    typedef struct {
        logic [2:0]  typ;
        logic [7:0]  opq;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic [1:0]  exp_test;
    } vec_t;

    typedef struct {
        logic [46:0] msg;
        int          acc_cyc;
    } sb_t;

    sb_t         sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_dlv = 0;
    bit          strict_timing = 1'b1;
    bit          rdy_at_neg = 1'b0;
    logic [46:0] exp_pending = '0;
    vec_t        vecs[13];

    function automatic vec_t mkv(input logic [2:0] typ, input logic [7:0] opq,
                                 input logic [31:0] addr, input logic [1:0] len,
                                 input logic [31:0] data, input logic [31:0] exp_data,
                                 input logic [1:0] exp_test);
        vec_t v;
        v.typ = typ; v.opq = opq; v.addr = addr; v.len = len;
        v.data = data; v.exp_data = exp_data; v.exp_test = exp_test;
        return v;
    endfunction

    function automatic logic [31:0] stream_data(input int k);
        return 32'h1000_0000 + 32'(k) * 32'h0011_0011;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // One clock: observe handshakes at the negedge, then step past the rising edge.
    task automatic cycle(output bit acc);
        sb_t e;
        @(negedge clk);
        acc        = mif.reqstream_val && mif.reqstream_rdy;
        rdy_at_neg = mif.reqstream_rdy;
        if (mif.respstream_val && mif.respstream_rdy) begin
            n_dlv++;
            $display("resp cyc=%0d opq=%h test=%b data=%h", cyc,
                     mif.respstream_msg[43:36], mif.respstream_msg[35:34], mif.respstream_msg[31:0]);
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_resp: got %h, required no response", mif.respstream_msg);
            end else begin
                e = sb_q.pop_front();
                chk("resp_msg", 64'(mif.respstream_msg), 64'(e.msg));
                if (strict_timing) chk("resp_latency", 64'(cyc - e.acc_cyc), 64'(LAT));
                else               chk("resp_min_latency", 64'((cyc - e.acc_cyc) >= LAT), 64'd1);
            end
        end
        if (acc) sb_q.push_back('{exp_pending, cyc});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input vec_t v, output int tries);
        bit acc;
        mif.reqstream_val = 1'b1;
        mif.reqstream_msg = {v.typ, v.opq, v.addr, v.len, v.data};
        exp_pending       = {v.typ, v.opq, v.exp_test, v.len, v.exp_data};
        tries = 0;
        do begin
            cycle(acc);
            tries++;
        end while (!acc && tries < 40);
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL req_accept_timeout: got no accept, required accept within 40 cycles");
        end
        mif.reqstream_val = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int t = 0;
        while (sb_q.size() != 0 && t < 60) begin
            cycle(acc);
            t++;
        end
        chk("drain_queue_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish within 200000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        int tries;
        int stalls;
        int accepted;
        int n_before;

        vecs[0]  = mkv(3'd2, 8'h01, 32'h200,           2'd0, 32'h0000_0013, 32'h0000_0000, 2'b00);
        vecs[1]  = mkv(3'd0, 8'h02, 32'h200,           2'd0, 32'h0,         32'h0000_0013, 2'b00);
        vecs[2]  = mkv(3'd1, 8'h03, SUB_BASE,          2'd0, 32'hDEAD_BEEF, 32'h0000_0000, 2'b00);
        vecs[3]  = mkv(3'd1, 8'h04, SUB_BASE + 32'd1,  2'd1, 32'h0000_0055, 32'h0000_0000, 2'b00);
        vecs[4]  = mkv(3'd0, 8'h05, SUB_BASE,          2'd0, 32'h0,         32'hDEAD_55EF, 2'b00);
        vecs[5]  = mkv(3'd0, 8'h06, SUB_BASE + 32'd2,  2'd2, 32'h0,         32'h0000_DEAD, 2'b00);
        vecs[6]  = mkv(3'd0, 8'h07, SUB_BASE + 32'd3,  2'd3, 32'h0,         32'h0000_00DE, 2'b00);
        vecs[7]  = mkv(3'd0, 8'h08, SUB_BASE + 32'd1,  2'd1, 32'h0,         32'h0000_0055, 2'b00);
        vecs[8]  = mkv(3'd1, 8'h09, SUB_BASE + 32'd2,  2'd2, 32'h0000_1234, 32'h0000_0000, 2'b00);
        vecs[9]  = mkv(3'd0, 8'h0A, SUB_BASE,          2'd0, 32'h0,         32'h1234_55EF, 2'b00);
        vecs[10] = mkv(3'd1, 8'h0B, SUB_BASE + 32'd3,  2'd0, 32'hCAFE_BABE, 32'h0000_0000, 2'b00);
        vecs[11] = mkv(3'd0, 8'h0C, SUB_BASE,          2'd0, 32'h0,         32'hBE34_55EF, 2'b00);
        vecs[12] = mkv(3'd0, 8'h0D, SUB_BASE + 32'd1,  2'd2, 32'h0,         32'h0000_3455, 2'b00);

        mif.reqstream_val  = 1'b0;
        mif.reqstream_msg  = '0;
        mif.respstream_rdy = 1'b1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_val", 64'(mif.respstream_val), 64'd0);
        chk("rst_req_rdy", 64'(mif.reqstream_rdy), 64'd0);
        reset = 1'b1;
        cycle(acc);
        chk("req_rdy_after_release", 64'(mif.reqstream_rdy), 64'd1);

        // Vector table: back-to-back with no backpressure, exact latency expected.
        strict_timing = 1'b1;
        for (int i = 0; i < 13; i++) begin
            send(vecs[i], tries);
        end
        drain();

        // Streaming: fill 16 words, then read them back one per cycle.
        for (int i = 0; i < 16; i++) begin
            send(mkv(3'd1, 8'(i), 32'h300 + 32'(4 * i), 2'd0, stream_data(i), 32'h0, 2'b00), tries);
        end
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            send(mkv(3'd0, 8'(i), 32'h300 + 32'(4 * i), 2'd0, 32'h0, stream_data(i), 2'b00), tries);
            stalls += tries - 1;
        end
        chk("stream_no_stall", 64'(stalls), 64'd0);
        drain();

        // Backpressure: offer up to 6 reads with the response side stalled.
        strict_timing = 1'b0;
        mif.respstream_rdy = 1'b0;
        accepted = 0;
        for (int t = 0; t < 8; t++) begin
            mif.reqstream_val = (accepted < 6);
            mif.reqstream_msg = {3'd0, 8'h40 + 8'(accepted), 32'h300 + 32'(4 * accepted), 2'd0, 32'h0};
            exp_pending       = {3'd0, 8'h40 + 8'(accepted), 2'b00, 2'd0, stream_data(accepted)};
            cycle(acc);
            if (acc) accepted++;
        end
        mif.reqstream_val = 1'b0;
        chk("bp_accepted", 64'(accepted), 64'd4);
        chk("bp_req_rdy_low", 64'(mif.reqstream_rdy), 64'd0);
        chk("bp_resp_val", 64'(mif.respstream_val), 64'd1);
        mif.respstream_rdy = 1'b1;
        cycle(acc);
        chk("bp_rdy_low_at_first_dlv", 64'(rdy_at_neg), 64'd0);
        chk("bp_rdy_back", 64'(mif.reqstream_rdy), 64'd1);
        drain();

        // Reset with three requests in flight.
        mif.respstream_rdy = 1'b0;
        send(mkv(3'd1, 8'h50, 32'h340, 2'd0, 32'h7766_5544, 32'h0, 2'b00), tries);
        send(mkv(3'd0, 8'h51, 32'h340, 2'd0, 32'h0, 32'h7766_5544, 2'b00), tries);
        send(mkv(3'd0, 8'h52, 32'h200, 2'd0, 32'h0, 32'h0000_0013, 2'b00), tries);
        reset = 1'b0;
        #1;
        chk("midrst_resp_val", 64'(mif.respstream_val), 64'd0);
        chk("midrst_req_rdy", 64'(mif.reqstream_rdy), 64'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        mif.respstream_rdy = 1'b1;
        n_before = n_dlv;
        cycle(acc);
        chk("midrst_rdy_after_release", 64'(mif.reqstream_rdy), 64'd1);
        repeat (5) cycle(acc);
        chk("midrst_no_stale", 64'(n_dlv - n_before), 64'd0);
        strict_timing = 1'b1;
        send(mkv(3'd0, 8'h53, 32'h340, 2'd0, 32'h0, 32'h7766_5544, 2'b00), tries);
        drain();

        // High address bits: aliasing or out-of-range flagging.
        send(mkv(3'd1, 8'h60, 32'h0,          2'd0, 32'h1111_1111, 32'h0, 2'b00), tries);
        send(mkv(3'd1, 8'h61, 32'h0001_0400,  2'd0, 32'hA5A5_A5A5, 32'h0, ALIAS_TEST), tries);
        send(mkv(3'd0, 8'h62, 32'h0,          2'd0, 32'h0, ALIAS_READ, 2'b00), tries);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
